// File: rtl/poly_fir_interp_pkg.sv
// Shared constants and helpers for the polyphase interpolating FIR: default
// raised-cosine table (Q1.7, index = p + 4k) and derived-width functions.
package poly_fir_pkg;

  localparam int DEF_N_PHASES = 4;
  localparam int DEF_N_TAPS   = 6;
  localparam int DEF_N_COEFF  = DEF_N_PHASES * DEF_N_TAPS;

  localparam logic signed [7:0] DEF_COEFF [DEF_N_COEFF] = '{
    8'sd0,   8'sd2,   8'sd2,   8'sd0,
    -8'sd8,  -8'sd16, -8'sd16, -8'sd1,
    8'sd33,  8'sd76,  8'sd113, 8'sd127,
    8'sd113, 8'sd76,  8'sd33,  8'sd0,
    -8'sd16, -8'sd16, -8'sd8,  -8'sd1,
    8'sd2,   8'sd2,   8'sd0,   8'sd0
  };

  function automatic int acc_width(input int nb_coeff, input int n_taps);
    return nb_coeff + 1 + $clog2(n_taps);
  endfunction

  function automatic int addr_width(input int n_phases, input int n_taps);
    return (n_phases * n_taps > 1) ? $clog2(n_phases * n_taps) : 1;
  endfunction

  function automatic bit is_default_geometry(input int n_phases, input int n_taps);
    return (n_phases == DEF_N_PHASES) && (n_taps == DEF_N_TAPS);
  endfunction

  // Out-of-table indices read as zero so callers never select past the table.
  function automatic logic signed [7:0] def_coeff(input int idx);
    if ((idx >= 0) && (idx < DEF_N_COEFF)) begin
      return DEF_COEFF[idx];
    end else begin
      return 8'sd0;
    end
  endfunction

endpackage

// File: rtl/poly_fir_interp_if.sv
// Symbol-in / sample-out bus of poly_fir_interp: ready/valid symbol input and
// tagged output samples.
interface poly_fir_interp_if #(
  parameter int N_CH      = 2,
  parameter int NB_OUTPUT = 8,
  parameter int N_PHASES  = 4
);
  logic                        i_valid;
  logic                        o_ready;
  logic [N_CH-1:0]             i_data;
  logic [N_CH*NB_OUTPUT-1:0]   o_data;
  logic                        o_valid;
  logic [$clog2(N_PHASES)-1:0] o_phase;

  modport master (output i_valid, i_data, input o_ready, o_data, o_valid, o_phase);
  modport slave  (input i_valid, i_data, output o_ready, o_data, o_valid, o_phase);
endinterface

// File: rtl/poly_fir_coeff_bank.sv
// Coefficient storage: writable register file with POLY_FIR_COEFF_LOAD_EN,
// otherwise the constant package table. Presents the taps of phase `ph`.
module poly_fir_coeff_bank
  import poly_fir_pkg::*;
#(
  parameter int NB_COEFF = 8,
  parameter int N_PHASES = 4,
  parameter int N_TAPS   = 6
) (
`ifdef POLY_FIR_COEFF_LOAD_EN
  input  logic                                        clk,
  input  logic                                        i_rst_n,
  input  logic                                        i_coeff_we,
  input  logic [addr_width(N_PHASES, N_TAPS)-1:0]     i_coeff_addr,
  input  logic [NB_COEFF-1:0]                         i_coeff_data,
`endif
  input  logic [$clog2(N_PHASES)-1:0]                 ph,
  output logic [N_TAPS*NB_COEFF-1:0]                  coeffs
);

  localparam int N_COEFF = N_PHASES * N_TAPS;
  localparam int NB_ADDR = addr_width(N_PHASES, N_TAPS);
  localparam bit IS_DEF  = is_default_geometry(N_PHASES, N_TAPS);

`ifdef POLY_FIR_COEFF_LOAD_EN
  logic [NB_COEFF-1:0] coeff_r [N_COEFF];

  // Coefficient register file; writes ignore i_en and out-of-range addresses.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_COEFF; i++) begin
        coeff_r[i] <= IS_DEF ? NB_COEFF'(def_coeff(i)) : {NB_COEFF{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_COEFF; i++) begin
        if (i_coeff_we && (i_coeff_addr == NB_ADDR'(i))) begin
          coeff_r[i] <= i_coeff_data;
        end
      end
    end
  end

  // Tap k of phase ph lives at index ph + k*N_PHASES.
  always_comb begin
    coeffs = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      coeffs[k*NB_COEFF +: NB_COEFF] = coeff_r[NB_ADDR'(int'(ph) + k * N_PHASES)];
    end
  end
`else
  if (!IS_DEF) begin : g_no_table
    $error("poly_fir_coeff_bank: no constant coefficient table for this geometry");
  end

  // Tap k of phase ph lives at index ph + k*N_PHASES.
  always_comb begin
    coeffs = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      coeffs[k*NB_COEFF +: NB_COEFF] = NB_COEFF'(def_coeff(int'(ph) + k * N_PHASES));
    end
  end
`endif

endmodule

// File: rtl/poly_fir_interp.sv
// Polyphase interpolating FIR for N_CH BPSK channels, N_PHASES samples per symbol.
// Define POLY_FIR_COEFF_LOAD_EN to add the runtime coefficient write port.
module poly_fir_interp
  import poly_fir_pkg::*;
#(
  parameter int NB_COEFF   = 8,
  parameter int NBF_COEFF  = 7,
  parameter int NB_OUTPUT  = 8,
  parameter int NBF_OUTPUT = 7,
  parameter int N_PHASES   = 4,
  parameter int N_TAPS     = 6,
  parameter int N_CH       = 2
) (
  input  logic                                    clk,
  input  logic                                    i_rst_n,
  input  logic                                    i_en,
`ifdef POLY_FIR_COEFF_LOAD_EN
  input  logic                                    i_coeff_we,
  input  logic [addr_width(N_PHASES, N_TAPS)-1:0] i_coeff_addr,
  input  logic [NB_COEFF-1:0]                     i_coeff_data,
`endif
  poly_fir_interp_if.slave                        bus
);

  localparam int NB_PH   = $clog2(N_PHASES);
  localparam int NB_TERM = NB_COEFF + 1;
  localparam int NB_ACC  = acc_width(NB_COEFF, N_TAPS);
  localparam int DROP    = NBF_COEFF - NBF_OUTPUT;
  localparam int NB_CMP  = ((NB_ACC > NB_OUTPUT) ? NB_ACC : NB_OUTPUT) + 1;
  localparam logic signed [NB_CMP-1:0] SAT_MAX = NB_CMP'((64'sd1 <<< (NB_OUTPUT - 1)) - 64'sd1);
  localparam logic signed [NB_CMP-1:0] SAT_MIN = NB_CMP'(-(64'sd1 <<< (NB_OUTPUT - 1)));
  localparam logic [NB_PH-1:0]         PH_LAST = NB_PH'(N_PHASES - 1);

  logic                        busy_r;
  logic [NB_PH-1:0]            ph_r;
  logic [N_TAPS-1:0]           sr_r [N_CH];
  logic [N_CH*NB_OUTPUT-1:0]   o_data_r;
  logic                        o_valid_r;
  logic [NB_PH-1:0]            o_phase_r;
  logic                        ready_s;
  logic                        accept_s;
  logic [N_TAPS*NB_COEFF-1:0]  coeffs_s;
  logic [N_CH*NB_OUTPUT-1:0]   sample_s;
  logic signed [NB_TERM-1:0]   term_s;
  logic signed [NB_ACC-1:0]    acc_s;
  logic signed [NB_CMP-1:0]    scaled_s;

  poly_fir_coeff_bank #(
    .NB_COEFF (NB_COEFF),
    .N_PHASES (N_PHASES),
    .N_TAPS   (N_TAPS)
  ) u_coeff_bank (
`ifdef POLY_FIR_COEFF_LOAD_EN
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_coeff_we   (i_coeff_we),
    .i_coeff_addr (i_coeff_addr),
    .i_coeff_data (i_coeff_data),
`endif
    .ph           (ph_r),
    .coeffs       (coeffs_s)
  );

  // Ready on the last phase too, so a new symbol chains on with no bubble.
  assign ready_s  = i_en & (~busy_r | (ph_r == PH_LAST));
  assign accept_s = ready_s & bus.i_valid;

  // Signed MAC per channel, truncate fractional LSBs, clamp to output range.
  always_comb begin
    sample_s = '0;
    term_s   = '0;
    acc_s    = '0;
    scaled_s = '0;
    for (int c = 0; c < N_CH; c++) begin
      acc_s = '0;
      for (int k = 0; k < N_TAPS; k++) begin
        // Widen before negating so the most negative coefficient negates exactly.
        term_s = NB_TERM'(signed'(coeffs_s[k*NB_COEFF +: NB_COEFF]));
        if (sr_r[c][k]) begin
          acc_s = acc_s - NB_ACC'(term_s);
        end else begin
          acc_s = acc_s + NB_ACC'(term_s);
        end
      end
      scaled_s = NB_CMP'(acc_s >>> DROP);
      if (scaled_s > SAT_MAX) begin
        sample_s[c*NB_OUTPUT +: NB_OUTPUT] = SAT_MAX[NB_OUTPUT-1:0];
      end else if (scaled_s < SAT_MIN) begin
        sample_s[c*NB_OUTPUT +: NB_OUTPUT] = SAT_MIN[NB_OUTPUT-1:0];
      end else begin
        sample_s[c*NB_OUTPUT +: NB_OUTPUT] = scaled_s[NB_OUTPUT-1:0];
      end
    end
  end

  // Phase sequencing, delay lines and registered output sample.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_r    <= 1'b0;
      ph_r      <= '0;
      o_data_r  <= '0;
      o_valid_r <= 1'b0;
      o_phase_r <= '0;
      for (int c = 0; c < N_CH; c++) begin
        sr_r[c] <= '0;
      end
    end else if (i_en) begin
      o_valid_r <= busy_r;
      if (busy_r) begin
        o_data_r  <= sample_s;
        o_phase_r <= ph_r;
      end
      if (accept_s) begin
        busy_r <= 1'b1;
        ph_r   <= '0;
        for (int c = 0; c < N_CH; c++) begin
          sr_r[c] <= N_TAPS'({sr_r[c], bus.i_data[c]});
        end
      end else if (busy_r) begin
        busy_r <= (ph_r != PH_LAST);
        ph_r   <= ph_r + NB_PH'(1'b1);
      end
    end else begin
      o_valid_r <= 1'b0;
    end
  end

  assign bus.o_ready = ready_s;
  assign bus.o_data  = o_data_r;
  assign bus.o_valid = o_valid_r & i_en;
  assign bus.o_phase = o_phase_r;

endmodule

// File: tb/tb_poly_fir_interp.sv
// Self-checking bench for poly_fir_interp against a queue-based reference model.
// Covers the coefficient write port when POLY_FIR_COEFF_LOAD_EN is defined.
module tb_poly_fir_interp;

  localparam int N_CH       = 2;
  localparam int NB_OUTPUT  = 8;
  localparam int NB_COEFF   = 8;
  localparam int NBF_COEFF  = 7;
  localparam int NBF_OUTPUT = 7;
  localparam int N_PHASES   = 4;
  localparam int N_TAPS     = 6;
  localparam int N_COEFF    = N_PHASES * N_TAPS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                i_rst_n;
  logic                i_en;
  logic                i_coeff_we;
  logic [4:0]          i_coeff_addr;
  logic [NB_COEFF-1:0] i_coeff_data;

  poly_fir_interp_if #(.N_CH(N_CH), .NB_OUTPUT(NB_OUTPUT), .N_PHASES(N_PHASES)) bus ();

  poly_fir_interp #(
    .NB_COEFF(NB_COEFF), .NBF_COEFF(NBF_COEFF), .NB_OUTPUT(NB_OUTPUT),
    .NBF_OUTPUT(NBF_OUTPUT), .N_PHASES(N_PHASES), .N_TAPS(N_TAPS), .N_CH(N_CH)
  ) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_en         (i_en),
`ifdef POLY_FIR_COEFF_LOAD_EN
    .i_coeff_we   (i_coeff_we),
    .i_coeff_addr (i_coeff_addr),
    .i_coeff_data (i_coeff_data),
`endif
    .bus          (bus)
  );

  // Reference model state: symbol history, coefficient set, pending phases.
  int def_tab [N_COEFF] = '{0, 2, 2, 0, -8, -16, -16, -1, 33, 76, 113, 127,
                            113, 76, 33, 0, -16, -16, -8, -1, 2, 2, 0, 0};
  int                        coef [N_COEFF];
  bit                        hist [N_CH][N_TAPS];
  int                        pend [$];
  logic [N_CH*NB_OUTPUT-1:0] exp_data;
  bit                        exp_valid;
  int                        exp_phase;
  int                        errors = 0;
  int                        checks = 0;
  int                        idle_cnt = 0;

  logic [15:0] vec_a  [4] = '{16'h7C7C, 16'h7C78, 16'h7C78, 16'h7D7D};
  logic [15:0] vec_ss [4] = '{16'h7C7C, 16'h7C7C, 16'h7C7C, 16'h7D7D};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output value of channel ch at phase p from the filter equation.
  function automatic int ref_sample(input int ch, input int p);
    int sum = 0;
    int lim = 1 << (NB_OUTPUT - 1);
    for (int k = 0; k < N_TAPS; k++) begin
      if (hist[ch][k]) sum -= coef[p + k * N_PHASES];
      else             sum += coef[p + k * N_PHASES];
    end
    sum = sum >>> (NBF_COEFF - NBF_OUTPUT);
    if (sum > lim - 1) sum = lim - 1;
    else if (sum < -lim) sum = -lim;
    return sum;
  endfunction

  task automatic model_reset();
    pend.delete();
    for (int c = 0; c < N_CH; c++)
      for (int k = 0; k < N_TAPS; k++) hist[c][k] = 1'b0;
    for (int i = 0; i < N_COEFF; i++) coef[i] = def_tab[i];
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_phase = 0;
  endtask

  // One clock: drive, check ready, advance model at the edge, check outputs.
  task automatic tick(input bit en, input bit vld, input logic [N_CH-1:0] d);
    bit exp_ready;
    int v;
    i_en = en; bus.i_valid = vld; bus.i_data = d;
    #1;
    exp_ready = en && (pend.size() <= 1);
    check("o_ready", bus.o_ready, exp_ready);
    check("o_valid_pre", bus.o_valid, exp_valid && en);
    @(posedge clk);
    if (en) begin
      if (pend.size() > 0) begin
        exp_phase = pend.pop_front();
        exp_valid = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
          v = ref_sample(c, exp_phase);
          exp_data[c*NB_OUTPUT +: NB_OUTPUT] = v[NB_OUTPUT-1:0];
        end
      end else begin
        exp_valid = 1'b0;
      end
      if (vld && exp_ready) begin
        for (int c = 0; c < N_CH; c++) begin
          for (int k = N_TAPS - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
          hist[c][0] = d[c];
        end
        for (int p = 0; p < N_PHASES; p++) pend.push_back(p);
      end
    end else begin
      exp_valid = 1'b0;
    end
    if (i_coeff_we && (i_coeff_addr < N_COEFF)) coef[i_coeff_addr] = $signed(i_coeff_data);
    #1;
    check("o_valid", bus.o_valid, exp_valid);
    check("o_phase", bus.o_phase, exp_phase);
    check("o_data", bus.o_data, exp_data);
    if (!bus.o_valid) idle_cnt++;
  endtask

  task automatic wr_coeff(input int addr, input int data, input bit en);
    i_coeff_we = 1'b1; i_coeff_addr = addr[4:0]; i_coeff_data = data[NB_COEFF-1:0];
    tick(en, 1'b0, '0);
    i_coeff_we = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #2; i_rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_o_valid", bus.o_valid, 1'b0);
    check("rst_o_data", bus.o_data, '0);
    check("rst_o_ready", bus.o_ready, i_en);
    #2; i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_en = 1'b0; bus.i_valid = 1'b0; bus.i_data = '0;
    i_coeff_we = 1'b0; i_coeff_addr = '0; i_coeff_data = '0;
    model_reset();
    #12;
    check("reset_o_valid", bus.o_valid, 1'b0);
    check("reset_o_data", bus.o_data, '0);
    check("reset_o_phase", bus.o_phase, '0);
    check("reset_o_ready_dis", bus.o_ready, 1'b0);
    i_en = 1'b1;
    #1;
    check("reset_o_ready_en", bus.o_ready, 1'b1);
    i_rst_n = 1'b1;

    // Single 2'b01 symbol after reset, then continuous zeros.
    tick(1'b1, 1'b1, 2'b01);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 2'b00);
      check("vec_a_data", bus.o_data, vec_a[i]);
      check("vec_a_phase", bus.o_phase, i);
    end
    repeat (28) tick(1'b1, 1'b1, 2'b00);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 2'b00);
      check("steady_data", bus.o_data, vec_ss[i]);
    end

    // Enable dropped mid-burst at phase 1, then resumed.
    repeat (5) tick(1'b1, 1'b0, 2'b00);
    tick(1'b1, 1'b1, 2'b10);
    tick(1'b1, 1'b0, 2'b00);
    repeat (5) tick(1'b0, 1'b1, 2'b11);
    tick(1'b1, 1'b0, 2'b00);
    check("resume_phase", bus.o_phase, 2'd1);
    repeat (3) tick(1'b1, 1'b0, 2'b00);

    // One symbol every six cycles leaves two idle cycles per six.
    repeat (2) tick(1'b1, 1'b0, 2'b00);
    tick(1'b1, 1'b1, N_CH'($urandom));
    idle_cnt = 0;
    repeat (2) begin
      repeat (5) tick(1'b1, 1'b0, 2'b00);
      tick(1'b1, 1'b1, N_CH'($urandom));
    end
    check("gap_count", idle_cnt, 4);
    repeat (4) tick(1'b1, 1'b0, 2'b00);

    // Randomized enable, valid and data.
    repeat (400) tick($urandom_range(0, 7) != 0, $urandom_range(0, 9) < 7, N_CH'($urandom));

    // Reset mid-burst with ones in the delay line; restart must see it cleared.
    repeat (5) tick(1'b1, 1'b0, 2'b00);
    repeat (5) tick(1'b1, 1'b1, 2'b11);
    tick(1'b1, 1'b0, 2'b00);
    async_reset();
    tick(1'b1, 1'b1, 2'b00);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 2'b00);
      check("post_rst_data", bus.o_data, vec_ss[i]);
      check("post_rst_phase", bus.o_phase, i);
    end

`ifdef POLY_FIR_COEFF_LOAD_EN
    // Phase-0 coefficients all set to 127 drive the sum into saturation.
    for (int k = 0; k < N_TAPS; k++) wr_coeff(k * N_PHASES, 127, k[0]);
    wr_coeff(25, -128, 1'b1);
    repeat (21) tick(1'b1, 1'b1, 2'b00);
    tick(1'b1, 1'b1, 2'b00);
    check("sat_pos_data", bus.o_data, 16'h7F7F);
    check("sat_pos_phase", bus.o_phase, 2'd0);
    repeat (23) tick(1'b1, 1'b1, 2'b11);
    tick(1'b1, 1'b1, 2'b11);
    check("sat_neg_data", bus.o_data, 16'h8080);
    check("sat_neg_phase", bus.o_phase, 2'd0);
    repeat (3) tick(1'b1, 1'b0, 2'b00);
    async_reset();
    tick(1'b1, 1'b1, 2'b00);
    tick(1'b1, 1'b0, 2'b00);
    check("coef_reset_data", bus.o_data, 16'h7C7C);
    repeat (3) tick(1'b1, 1'b0, 2'b00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/poly_fir_interp.md
# poly_fir_interp

Parametrised polyphase interpolating FIR for BPSK symbol shaping, next generation of the fixed 4-phase/6-tap filter. It supports `N_CH` parallel 1-bit symbol channels (e.g. I and Q), with geometry and fixed-point formats set by parameters. It has an optional runtime coefficient write port, a ready/valid input handshake and a registered, saturated output with valid and phase tags. It sits between the symbol mapper and the DAC-side datapath, producing `N_PHASES` output samples per accepted symbol.

## Interface
- `NB_COEFF`, 8, coefficient width (signed)
- `NBF_COEFF`, 7, coefficient fractional bits
- `NB_OUTPUT`, 8, output sample width (signed)
- `NBF_OUTPUT`, 7, output fractional bits; must be ≤ `NBF_COEFF`
- `N_PHASES`, 4, oversampling factor; power of two, ≥2
- `N_TAPS`, 6, taps per phase; ≥1
- `N_CH`, 2, independent symbol channels; all channels share one coefficient set
- `clk` in 1: clock
- `i_rst_n` in 1: asynchronous, active-low reset
- `i_en` in 1: global enable; 0 freezes all state
- `i_valid` in 1: input symbol vector valid
- `o_ready` out 1: block can accept a symbol this cycle
- `i_data` in `N_CH`: one symbol bit per channel; 0 → +coeff, 1 → −coeff
- `o_data` out `N_CH*NB_OUTPUT`: channel c occupies bits [c*NB_OUTPUT +: NB_OUTPUT]
- `o_valid` out 1: `o_data` holds a new sample
- `o_phase` out clog2(`N_PHASES`): phase index of the current `o_data`
- `i_coeff_we` in 1: coefficient write strobe (present only with the macro)
- `i_coeff_addr` in clog2(`N_PHASES*N_TAPS`): coefficient index (present only with the macro)
- `i_coeff_data` in `NB_COEFF`: coefficient value (present only with the macro)

## Operation
- Per channel: delay line `sr[0..N_TAPS-1]`, where `sr[0]` is the newest symbol.
  - Filter output for phase p = Σk (`sr[k]` ? −c[p+k·N_PHASES] : +c[p+k·N_PHASES]).
- Control state:
  - `busy` flag and phase counter `ph`.
  - `o_ready` = !`busy` | (`ph`==`N_PHASES`−1).
- Accept when `i_en` & `i_valid` & `o_ready`:
  - Delay lines shift and `sr[0]` ← `i_data`.
  - `ph` ← 0, `busy` ← 1.
- Each edge with `i_en` & `busy`:
  - `o_data` ← saturated sum for the current `ph` on the already-updated delay line.
  - `o_phase` ← `ph`, `o_valid` ← 1.
  - `ph` ← `ph`+1.
  - At `ph`==`N_PHASES`−1: `busy` clears unless a new accept happens on the same edge. Accept has priority, so `ph` ← 0 and `busy` stays 1.
- An edge with `i_en` & !`busy` sets `o_valid` ← 0 and holds `o_data`.
- While `i_en`=0: all state holds, including delay lines, counter, coefficients and `o_data`. `o_valid` is forced to 0 and `o_ready` is forced to 0.
- Arithmetic:
  - Each product is sign-extended to `NB_COEFF`+1 bits before negation, so −(−2^(`NB_COEFF`−1)) is exact.
  - Accumulator width = `NB_COEFF`+1+clog2(`N_TAPS`), carrying `NBF_COEFF` fractional bits.
  - Output drops `NBF_COEFF`−`NBF_OUTPUT` LSBs by truncation.
  - Saturates to [−2^(`NB_OUTPUT`−1), 2^(`NB_OUTPUT`−1)−1] when the discarded integer MSBs are not all-equal.
- Coefficient write (with the macro):
  - c[`i_coeff_addr`] ← `i_coeff_data` on the edge where `i_coeff_we`=1, independent of `i_en`.
  - Addresses ≥ `N_PHASES*N_TAPS` are ignored.
  - Writes during `busy` are allowed; the new value is used from the next computed phase onward.

## Timing
- Reset values:
  - `o_data`=0, `o_valid`=0, `o_phase`=0, `busy`=0, `ph`=0, all delay taps 0.
  - `o_ready`=1 once `i_en`=1.
- Latency: a symbol accepted at edge E0 produces phase 0 at E1 and phase `N_PHASES`−1 at E`N_PHASES`.
- Throughput: a symbol presented every `N_PHASES` cycles gives continuous `o_valid`=1, with `o_phase` cycling 0…`N_PHASES`−1 and no bubble.
- Slower input inserts `o_valid`=0 cycles between sample bursts.
- Reset asserted mid-burst aborts the burst immediately. The next accepted symbol starts at phase 0 on a zeroed delay line.

## Configuration
- `POLY_FIR_COEFF_LOAD_EN` defined:
  - Write port present; coefficients are `N_PHASES*N_TAPS` registers.
  - Registers reset asynchronously to the package default table. If the geometry is not the default one, they reset to zero.
- `POLY_FIR_COEFF_LOAD_EN` undefined:
  - Write-port inputs are absent.
  - Coefficients are constants from the package default table. Non-default geometries require a package table for that geometry, or elaboration fails.

## Structure
- Package `poly_fir_pkg`:
  - Default 24-entry raised-cosine table, Q1.7, index = p+4k: 0,2,2,0, −8,−16,−16,−1, 33,76,113,127, 113,76,33,0, −16,−16,−8,−1, 2,2,0,0.
  - Accumulator-width and address-width constants/functions.
- Sub-module `poly_fir_coeff_bank`:
  - Register file with write port, or constant table, selected by the macro.
  - Exposes the `N_TAPS` coefficients of the phase selected by `ph`.

## Test plan
- All-zero symbols on both channels, defaults, continuous input: steady-state phases 0/1/2/3 → 124/124/124/125 (0x7C,0x7C,0x7C,0x7D) on both channels.
- After reset, one symbol `i_data`=2'b01, then all-zero symbols: ch0 phases → 124,120,120,125; ch1 → 124,124,124,125. Check `o_valid`/`o_phase` against the latency rule.
- Back-to-back accepts at `ph`==3: `o_valid` stays 1 with no bubble. A symbol every 6 cycles gives 2 `o_valid`=0 cycles per 6.
- `i_en` dropped for 5 cycles mid-burst at `ph`=1: outputs hold, `o_valid`=0, `o_ready`=0. On re-enable the burst resumes with phase 1 and nothing is lost or duplicated.
- Macro on: write phase-0 coefficients (addr 0,4,8,12,16,20) to 127. All-zero symbols → phase 0 = 0x7F (saturated from 762); all-one symbols → 0x80.
- `i_rst_n` pulsed asynchronously mid-burst: `o_valid`, `o_data` and `busy` go to 0 immediately. The next symbol restarts at phase 0 with the delay line cleared.
